// File: rtl/jump_charge_ctrl_pkg.sv
// Shared constants, state encoding and speed helper for the jump charge controller.
package jump_charge_ctrl_pkg;

  localparam int SQUEEZE_MAX = 14;
  localparam int V_INIT_MAX  = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REL,
    ST_READY,
    ST_CHARGE,
    ST_LAUNCH,
    ST_FLIGHT
  } state_t;

  // Speed is formed in 12 bits so squeeze*step cannot wrap before saturation.
  function automatic logic [7:0] sat_speed(input logic [3:0] squeeze, input int v_base,
                                           input int v_step);
    logic [11:0] v;
    v = 12'(v_base) + 12'(squeeze) * 12'(v_step);
    if (v > 12'(V_INIT_MAX)) begin
      return 8'(V_INIT_MAX);
    end
    return v[7:0];
  endfunction

endpackage

// File: rtl/jump_charge_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stable-level counter for the raw jump button.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_q
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;

  // The counter only advances while the synchronised sample disagrees with btn_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      cnt_reg  <= '0;
      btn_q    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      if (sync_reg[1] != btn_q) begin
        if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
          btn_q   <= sync_reg[1];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/jump_charge_ctrl.sv
// Jump sequencer: turns button hold time into squeeze level and launch speed,
// then runs the enable/done handshake with the jump module.
module jump_charge_ctrl
  import jump_charge_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES     = 250000,
  parameter int TICK_CYCLES    = 1500000,
  parameter int V_BASE         = 20,
  parameter int V_STEP         = 8,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn,
  input  logic       i_arm,
  input  logic       i_jump_done,
  output logic       o_jump_en,
  output logic [7:0] o_v_init,
  output logic [3:0] o_squeeze,
  output logic       o_busy,
  output logic       o_land,
  output logic       o_timeout
);

  localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t         state_reg;
  logic [TW-1:0]  tick_reg;
  logic [TOW-1:0] to_cnt_reg;
  logic [1:0]     done_sync_reg;
  logic           btn_q;
  logic           btn_prev_reg;
  logic           jump_en_reg;
  logic [7:0]     v_init_reg;
  logic [3:0]     squeeze_reg;
  logic           busy_reg;
  logic           land_reg;
  logic           timeout_reg;
  logic           done_s;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (i_btn),
    .btn_q(btn_q)
  );

  assign done_s = done_sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tick_reg      <= '0;
      to_cnt_reg    <= '0;
      done_sync_reg <= 2'b00;
      btn_prev_reg  <= 1'b0;
      jump_en_reg   <= 1'b0;
      v_init_reg    <= 8'd0;
      squeeze_reg   <= 4'd0;
      busy_reg      <= 1'b0;
      land_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      done_sync_reg <= {done_sync_reg[0], i_jump_done};
      btn_prev_reg  <= btn_q;
      land_reg      <= 1'b0;
      timeout_reg   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          squeeze_reg <= 4'd0;
          busy_reg    <= 1'b0;
          jump_en_reg <= 1'b0;
          if (i_arm) begin
            state_reg <= ST_WAIT_REL;
          end
        end

        // A press already held when arming must be released first.
        ST_WAIT_REL: begin
          if (!i_arm) begin
            state_reg <= ST_IDLE;
          end else if (!btn_q) begin
            state_reg <= ST_READY;
          end
        end

        ST_READY: begin
          if (!i_arm) begin
            state_reg <= ST_IDLE;
          end else if (btn_q && !btn_prev_reg) begin
            state_reg   <= ST_CHARGE;
            squeeze_reg <= 4'd0;
            tick_reg    <= '0;
            busy_reg    <= 1'b1;
          end
        end

        // Abort outranks release; a release at squeeze 0 is a tap and is discarded.
        ST_CHARGE: begin
          if (!i_arm) begin
            state_reg   <= ST_IDLE;
            squeeze_reg <= 4'd0;
            busy_reg    <= 1'b0;
          end else if (!btn_q) begin
            if (squeeze_reg == 4'd0) begin
              state_reg <= ST_READY;
              busy_reg  <= 1'b0;
            end else begin
              state_reg   <= ST_LAUNCH;
              v_init_reg  <= sat_speed(squeeze_reg, V_BASE, V_STEP);
              jump_en_reg <= 1'b1;
              to_cnt_reg  <= '0;
            end
          end else if (tick_reg == TW'(TICK_CYCLES - 1)) begin
            tick_reg <= '0;
            if (squeeze_reg != 4'(SQUEEZE_MAX)) begin
              squeeze_reg <= squeeze_reg + 4'd1;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end

        // Wait for any done level left over from the previous jump to clear.
        ST_LAUNCH: begin
          if (to_cnt_reg == TOW'(TIMEOUT_CYCLES - 1)) begin
            state_reg   <= ST_IDLE;
            land_reg    <= 1'b1;
            timeout_reg <= 1'b1;
            jump_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            squeeze_reg <= 4'd0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (!done_s) begin
              state_reg <= ST_FLIGHT;
            end
          end
        end

        ST_FLIGHT: begin
          if (done_s || (to_cnt_reg == TOW'(TIMEOUT_CYCLES - 1))) begin
            state_reg   <= ST_IDLE;
            land_reg    <= 1'b1;
            timeout_reg <= !done_s;
            jump_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            squeeze_reg <= 4'd0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_jump_en = jump_en_reg;
  assign o_v_init  = v_init_reg;
  assign o_squeeze = squeeze_reg;
  assign o_busy    = busy_reg;
  assign o_land    = land_reg;
  assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// Directed bench for jump_charge_ctrl with small timing parameters.
module tb_jump_charge_ctrl;

  logic       clk;
  logic       rst;
  logic       i_btn;
  logic       i_arm;
  logic       i_jump_done;
  logic       o_jump_en;
  logic [7:0] o_v_init;
  logic [3:0] o_squeeze;
  logic       o_busy;
  logic       o_land;
  logic       o_timeout;

  logic       b_jump_en;
  logic [7:0] b_v_init;
  logic [3:0] b_squeeze;
  logic       b_busy;
  logic       b_land;
  logic       b_timeout;

  int checks = 0;
  int errors = 0;
  int saw_en = 0;
  int saw_busy = 0;
  int lands = 0;

  jump_charge_ctrl #(
    .DEB_CYCLES(4), .TICK_CYCLES(10), .V_BASE(20), .V_STEP(8), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_arm(i_arm), .i_jump_done(i_jump_done),
    .o_jump_en(o_jump_en), .o_v_init(o_v_init), .o_squeeze(o_squeeze),
    .o_busy(o_busy), .o_land(o_land), .o_timeout(o_timeout)
  );

  jump_charge_ctrl #(
    .DEB_CYCLES(4), .TICK_CYCLES(10), .V_BASE(20), .V_STEP(20), .TIMEOUT_CYCLES(200)
  ) dut_big (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_arm(i_arm), .i_jump_done(i_jump_done),
    .o_jump_en(b_jump_en), .o_v_init(b_v_init), .o_squeeze(b_squeeze),
    .o_busy(b_busy), .o_land(b_land), .o_timeout(b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (o_jump_en) saw_en++;
      if (o_busy) saw_busy++;
      if (o_land) lands++;
    end
  endtask

  task automatic clear_mon();
    saw_en = 0;
    saw_busy = 0;
    lands = 0;
  endtask

  task automatic press(input int n);
    i_btn = 1'b1;
    step(n);
    i_btn = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_jump_en) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_land(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (o_land) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; i_btn = 1'b0; i_arm = 1'b0; i_jump_done = 1'b0;
    step(3);
    checks++;
    if ({o_jump_en, o_v_init, o_squeeze, o_busy, o_land, o_timeout} !== 16'd0) begin
      errors++;
      $display("FAIL reset_init: outputs=%h expected 0",
               {o_jump_en, o_v_init, o_squeeze, o_busy, o_land, o_timeout});
    end
    rst = 1'b0;
    i_arm = 1'b1; step(3);
    i_btn = 1'b1; step(15);
    rst = 1'b1; i_arm = 1'b0; step(3);
    checks++;
    if ({o_jump_en, o_squeeze, o_busy, o_land} !== 7'd0) begin
      errors++;
      $display("FAIL reset_charge: en=%b sq=%0d busy=%b land=%b expected 0",
               o_jump_en, o_squeeze, o_busy, o_land);
    end
    rst = 1'b0; clear_mon();
    step(20);
    checks++;
    if (saw_busy !== 0) begin
      errors++;
      $display("FAIL reset_needs_arm: busy cycles=%0d expected 0", saw_busy);
    end
    i_btn = 1'b0; step(10);
    i_arm = 1'b1; step(3);
    press(35);
    wait_en(ok);
    step(2);
    rst = 1'b1; clear_mon();
    step(1);
    checks++;
    if (o_jump_en !== 1'b0 || !ok) begin
      errors++;
      $display("FAIL reset_flight_en: en=%b reached_flight=%b expected en 0", o_jump_en, ok);
    end
    i_arm = 1'b0;
    step(2);
    checks++;
    if (lands !== 0 || o_v_init !== 8'd0) begin
      errors++;
      $display("FAIL reset_flight_land: lands=%0d v=%0d expected 0 and 0", lands, o_v_init);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_normal_jump();
    bit ok;
    clear_mon();
    i_jump_done = 1'b0; i_arm = 1'b1;
    step(3);
    press(35);
    wait_en(ok);
    checks++;
    if (!ok || o_squeeze !== 4'd3 || o_v_init !== 8'd44 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_launch: en=%b sq=%0d v=%0d busy=%b expected 1 3 44 1",
               o_jump_en, o_squeeze, o_v_init, o_busy);
    end
    step(4);
    i_arm = 1'b0;
    checks++;
    if (o_jump_en !== 1'b1 || lands !== 0) begin
      errors++;
      $display("FAIL normal_flight: en=%b lands=%0d expected 1 0", o_jump_en, lands);
    end
    i_jump_done = 1'b1;
    wait_land(ok);
    checks++;
    if (!ok || o_timeout !== 1'b0 || o_squeeze !== 4'd0 || o_jump_en !== 1'b0 ||
        o_busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_land: land=%b to=%b sq=%0d en=%b busy=%b expected 1 0 0 0 0",
               o_land, o_timeout, o_squeeze, o_jump_en, o_busy);
    end
    step(3);
    checks++;
    if (o_land !== 1'b0 || lands !== 1 || o_v_init !== 8'd44) begin
      errors++;
      $display("FAIL normal_single_land: lands=%0d v=%0d expected 1 44", lands, o_v_init);
    end
    i_jump_done = 1'b0;
    step(5);
  endtask

  task automatic test_saturate();
    bit ok;
    i_arm = 1'b1;
    step(3);
    press(300);
    wait_en(ok);
    checks++;
    if (!ok || o_squeeze !== 4'd14 || o_v_init !== 8'd132) begin
      errors++;
      $display("FAIL saturate_v8: en=%b sq=%0d v=%0d expected 1 14 132",
               o_jump_en, o_squeeze, o_v_init);
    end
    checks++;
    if (b_v_init !== 8'd255 || b_squeeze !== 4'd14) begin
      errors++;
      $display("FAIL saturate_v20: v=%0d sq=%0d expected 255 14", b_v_init, b_squeeze);
    end
    i_jump_done = 1'b1;
    wait_land(ok);
    i_jump_done = 1'b0; i_arm = 1'b0;
    step(5);
  endtask

  task automatic test_tap();
    i_arm = 1'b1;
    step(3);
    clear_mon();
    press(7);
    step(15);
    checks++;
    if (saw_en !== 0 || saw_busy == 0 || o_busy !== 1'b0 || o_squeeze !== 4'd0) begin
      errors++;
      $display("FAIL tap: en_cycles=%0d busy_cycles=%0d busy=%b sq=%0d expected 0 >0 0 0",
               saw_en, saw_busy, o_busy, o_squeeze);
    end
    i_arm = 1'b0;
    step(2);
  endtask

  task automatic test_arm_abort();
    clear_mon();
    i_btn = 1'b1; step(10);
    i_arm = 1'b1; step(20);
    checks++;
    if (saw_busy !== 0) begin
      errors++;
      $display("FAIL held_before_arm: busy cycles=%0d expected 0", saw_busy);
    end
    i_btn = 1'b0; step(10);
    i_btn = 1'b1; step(20);
    checks++;
    if (o_busy !== 1'b1 || o_squeeze !== 4'd1) begin
      errors++;
      $display("FAIL charge_after_repress: busy=%b sq=%0d expected 1 1", o_busy, o_squeeze);
    end
    i_arm = 1'b0;
    step(2);
    checks++;
    if (o_busy !== 1'b0 || o_squeeze !== 4'd0 || saw_en !== 0 || lands !== 0) begin
      errors++;
      $display("FAIL arm_abort: busy=%b sq=%0d en_cycles=%0d lands=%0d expected 0 0 0 0",
               o_busy, o_squeeze, saw_en, lands);
    end
    i_btn = 1'b0;
    step(10);
  endtask

  task automatic test_timeout();
    bit ok;
    int en_cnt;
    bit landed;
    i_jump_done = 1'b1;
    step(5);
    i_arm = 1'b1;
    step(3);
    press(35);
    wait_en(ok);
    clear_mon();
    en_cnt = ok ? 1 : 0;
    landed = 1'b0;
    for (int i = 0; i < 400 && ok; i++) begin
      step(1);
      if (o_land) begin
        landed = 1'b1;
        break;
      end
      if (o_jump_en) en_cnt++;
    end
    checks++;
    if (!landed || en_cnt !== 200) begin
      errors++;
      $display("FAIL timeout_len: landed=%b en_cycles=%0d expected 1 200", landed, en_cnt);
    end
    checks++;
    if (o_timeout !== 1'b1 || o_jump_en !== 1'b0 || o_squeeze !== 4'd0 || lands !== 1) begin
      errors++;
      $display("FAIL timeout_flags: to=%b en=%b sq=%0d lands=%0d expected 1 0 0 1",
               o_timeout, o_jump_en, o_squeeze, lands);
    end
    i_arm = 1'b0;
    step(2);
    checks++;
    if (o_timeout !== 1'b0 || o_v_init !== 8'd44) begin
      errors++;
      $display("FAIL timeout_after: to=%b v=%0d expected 0 44", o_timeout, o_v_init);
    end
  endtask

  initial begin
    test_reset();
    test_normal_jump();
    test_saturate();
    test_tap();
    test_arm_abort();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
